// File: rtl/uart_tx_ctrl.sv
// UART transmit controller feeding a tx_piso shift register.
// Takes one byte per valid/ready handshake, generates baud timing, strobes
// the PISO's load/shift inputs and drives the complete serial frame:
// start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
//
// Handshake: a byte is accepted on a clk edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE. While a frame is in progress tx_valid and
// tx_data are ignored, and the producer may change them freely.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       piso_load,
    output logic       piso_shift,
    output logic [7:0] piso_data,
    input  logic       piso_out,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int            CW         = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic          ODD_BIT    = (PARITY_ODD != 0);
    localparam bit            HAS_PARITY = (PARITY_EN != 0);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_baud_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_data;
    logic          w_bit_end;
    logic          w_take;

    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
    assign w_take      = tx_valid && (r_state == S_IDLE);
    assign tx_ready    = (r_state == S_IDLE);
    assign tx_busy     = (r_state != S_IDLE);
    assign piso_data   = r_data;
    assign o_dbg_state = r_state;

    // State, baud counter, bit counter and latched byte.
    // bit_cnt counts data bits in DATA and stop bits in STOP; both counters
    // restart from zero on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_data <= tx_data;
            end
            if ((w_state_nxt != r_state) || (r_state == S_IDLE) || w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP))) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Next state and per-state line / PISO strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        tx_serial   = 1'b1;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        tx_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                tx_serial = 1'b0;
                // Load only on the first START cycle so the PISO holds the
                // byte for the rest of START.
                piso_load = (r_baud_cnt == '0);
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                tx_serial = piso_out;
                if (w_bit_end) begin
                    if (r_bit_cnt != 3'd7) begin
                        // Advance the PISO to the next bit; none after bit 7.
                        piso_shift = 1'b1;
                    end else begin
                        w_state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                tx_serial = (^r_data) ^ ODD_BIT;
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end && (r_bit_cnt == STOP_LAST)) begin
                    tx_done     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three instances with different framing options,
// each followed by a small behavioural tx_piso. Expected line levels are
// computed from the frame layout (bit position = cycle / CLKS_PER_BIT).
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  logic       clk;
  logic       reset;
  logic [2:0] tx_valid;
  logic [7:0] tx_data    [3];
  logic       tx_ready   [3];
  logic       piso_load  [3];
  logic       piso_shift [3];
  logic [7:0] piso_data  [3];
  logic       piso_out   [3];
  logic       tx_serial  [3];
  logic       tx_busy    [3];
  logic       tx_done    [3];
  logic [2:0] dbg_state  [3];
  logic [7:0] piso_reg   [3];

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  bit         mon_en;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .piso_load(piso_load[0]), .piso_shift(piso_shift[0]),
    .piso_data(piso_data[0]), .piso_out(piso_out[0]), .tx_serial(tx_serial[0]),
    .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .o_dbg_state(dbg_state[0])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .piso_load(piso_load[1]), .piso_shift(piso_shift[1]),
    .piso_data(piso_data[1]), .piso_out(piso_out[1]), .tx_serial(tx_serial[1]),
    .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .o_dbg_state(dbg_state[1])
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .piso_load(piso_load[2]), .piso_shift(piso_shift[2]),
    .piso_data(piso_data[2]), .piso_out(piso_out[2]), .tx_serial(tx_serial[2]),
    .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .o_dbg_state(dbg_state[2])
  );

  // Behavioural tx_piso: load wins, shift moves toward the LSB.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) piso_reg[i] <= 8'h00;
      else if (piso_load[i]) piso_reg[i] <= piso_data[i];
      else if (piso_shift[i]) piso_reg[i] <= {1'b0, piso_reg[i][7:1]};
    end
  end
  assign piso_out[0] = piso_reg[0][0];
  assign piso_out[1] = piso_reg[1][0];
  assign piso_out[2] = piso_reg[2][0];

  // ---------------- reference model ----------------
  function automatic int pen(input int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int podd(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  function automatic int nstop(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int i);
    return (10 + pen(i) + nstop(i) - 1) * CPB;
  endfunction

  // Line level k cycles after the first START cycle.
  function automatic logic exp_line(input int i, input logic [7:0] b, input int k);
    int pos;
    pos = k / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && pen(i) != 0) return logic'(($countones(b) + podd(i)) % 2);
    return 1'b1;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int i, input string tag);
    chk($sformatf("%s_d%0d_serial", tag, i), tx_serial[i], 1'b1);
    chk($sformatf("%s_d%0d_ready", tag, i), tx_ready[i], 1'b1);
    chk($sformatf("%s_d%0d_busy", tag, i), tx_busy[i], 1'b0);
    chk($sformatf("%s_d%0d_done", tag, i), tx_done[i], 1'b0);
    chk($sformatf("%s_d%0d_load", tag, i), piso_load[i], 1'b0);
    chk($sformatf("%s_d%0d_shift", tag, i), piso_shift[i], 1'b0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with DUT i idle; sends n bytes popped from tx_q and
  // checks every cycle of each frame plus the idle gap after it. With hold=1
  // tx_valid stays high across frames. Returns at a negedge, DUT idle.
  task automatic send_frames(input int i, input int n, input bit hold);
    logic [7:0] b;
    int len;
    int loads;
    int shifts;
    len = frame_len(i);
    b = tx_q.pop_front();
    for (int f = 0; f < n; f++) begin
      tx_valid[i] = 1'b1;
      tx_data[i] = b;
      chk($sformatf("d%0d_ready_before_f%0d", i, f), tx_ready[i], 1'b1);
      if (i == 0 && mon_en) exp_q.push_back(b);
      loads = 0;
      shifts = 0;
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        if (k == 0 && !hold) tx_valid[i] = 1'b0;
        chk($sformatf("d%0d_b%02h_line_k%0d", i, b, k), tx_serial[i], exp_line(i, b, k));
        chk($sformatf("d%0d_busy_k%0d", i, k), tx_busy[i], 1'b1);
        chk($sformatf("d%0d_ready_k%0d", i, k), tx_ready[i], 1'b0);
        chk($sformatf("d%0d_done_k%0d", i, k), tx_done[i], (k == len - 1));
        chk($sformatf("d%0d_ld_sh_excl_k%0d", i, k), piso_load[i] & piso_shift[i], 1'b0);
        if (piso_load[i]) loads++;
        if (piso_shift[i]) shifts++;
        if (k == len / 2) tx_data[i] = 8'($urandom_range(0, 255));
        if (k == len - 1) begin
          if (f < n - 1) begin
            b = tx_q.pop_front();
            tx_data[i] = b;
          end else begin
            tx_valid[i] = 1'b0;
          end
        end
      end
      chk($sformatf("d%0d_load_count", i), loads, 1);
      chk($sformatf("d%0d_shift_count", i), shifts, 7);
      @(negedge clk);
      check_idle(i, "gap");
    end
  endtask

  // ---------------- mid-bit monitor and scoreboard (DUT 0) ----------------
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (mon_en && tx_serial[0] === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        chk("mon_start", tx_serial[0], 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          d[b] = tx_serial[0];
        end
        repeat (CPB) @(negedge clk);
        chk("mon_stop", tx_serial[0], 1'b1);
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_frame", d, 8'h00 ^ ~d);
        end else begin
          chk("mon_byte", d, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;
    bad = 0;
    mon_en = 1'b0;
    reset = 1'b1;
    tx_valid = 3'b000;
    for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
    repeat (3) @(negedge clk);

    // reset values, reset still asserted
    for (int i = 0; i < 3; i++) begin
      check_idle(i, "rst");
      chk($sformatf("rst_d%0d_piso_data", i), piso_data[i], 8'h00);
    end
    reset = 1'b0;
    mon_en = 1'b1;

    // quiet line
    repeat (50) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_idle(i, "quiet");
    end

    // single frames of 8'hAD on each framing option
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(8'hAD);
      send_frames(i, 1, 1'b0);
    end

    // back-to-back with tx_valid held
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h0F);
    send_frames(0, 2, 1'b1);

    // reset during data bit 3 of 8'hFF
    mon_en = 1'b0;
    tx_valid[0] = 1'b1;
    tx_data[0] = 8'hFF;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 0) tx_valid[0] = 1'b0;
      chk($sformatf("abort_line_k%0d", k), tx_serial[0], exp_line(0, 8'hFF, k));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle(0, "abort");
    mon_en = 1'b1;
    tx_q.push_back(8'h81);
    send_frames(0, 1, 1'b0);

    // random back-to-back traffic
    for (int j = 0; j < 256; j++) tx_q.push_back(8'($urandom_range(0, 255)));
    send_frames(0, 256, 1'b1);
    for (int j = 0; j < 16; j++) tx_q.push_back(8'($urandom_range(0, 255)));
    send_frames(1, 16, 1'b0);
    for (int j = 0; j < 16; j++) tx_q.push_back(8'($urandom_range(0, 255)));
    send_frames(2, 16, 1'b1);

    repeat (4) @(negedge clk);
    chk("mon_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
